sec_bcd_counter: RTL and testbench

Timebase and 8-digit BCD seconds counter feeding the multiplexed seven-segment display driver. It divides the system clock to a 1 Hz tick and counts elapsed seconds in eight BCD digits under start/stop, clear and load control. It also generates the free-running 3-bit digit-scan index and the per-digit decimal-point bits. All digit, scan and dp outputs connect one-to-one to the display driver's `cnt_d*`, `seven_seg_scan` and `dp*` inputs.

---
 rtl/sec_bcd_pkg.sv | 36 +++
 rtl/sec_bcd_counter_digit.sv | 41 ++++
 rtl/sec_bcd_counter.sv | 139 +++++++++++++
 tb/tb_sec_bcd_counter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/sec_bcd_pkg.sv
// Shared types and helpers for the seconds counter: digit count, BCD limits,
// run/stop state encoding and the single-decade increment.
package sec_bcd_pkg;

    localparam int NUM_DIGITS = 8;
    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef enum logic {
        STOP = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic       cout;
        logic [3:0] nib;
    } bcd_step_t;

    function automatic bcd_step_t bcd_wrap(input logic [3:0] d, input logic cin);
        bcd_step_t r;
        r.cout = cin && (d == BCD_MAX);
        if (!cin) begin
            r.nib = d;
        end else if (d == BCD_MAX) begin
            r.nib = 4'd0;
        end else begin
            r.nib = d + 4'd1;
        end
        return r;
    endfunction

    // Out-of-range load nibbles are forced to 0 so digits never hold a non-BCD code.
    function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
        return (d > BCD_MAX) ? 4'd0 : d;
    endfunction

endpackage

// File: rtl/sec_bcd_counter_digit.sv
// One BCD decade of the seconds chain: clear, load or carry-driven increment,
// with a combinational carry out so the eight decades ripple in one cycle.
module bcd_digit
    import sec_bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       load,
    input  logic [3:0] load_nib,
    input  logic       cin,
    output logic [3:0] q,
    output logic       cout
);

    bcd_step_t  step;
    logic [3:0] q_q;
    logic [3:0] q_d;

    always_comb begin
        step = bcd_wrap(q_q, cin);
        q_d  = step.nib;
        if (clr) begin
            q_d = 4'd0;
        end else if (load) begin
            q_d = bcd_clamp(load_nib);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q <= 4'd0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q    = q_q;
    assign cout = step.cout;

endmodule

// File: rtl/sec_bcd_counter.sv
// Seconds timebase: run/stop FSM, 1 Hz prescaler, eight-decade BCD count,
// free-running display scan index and the dp0 heartbeat.
module sec_bcd_counter
    import sec_bcd_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int SCAN_DIV = 50_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_stop,
    input  logic        clr,
    input  logic        load,
    input  logic [31:0] load_val,
    output logic [3:0]  cnt_d0,
    output logic [3:0]  cnt_d1,
    output logic [3:0]  cnt_d2,
    output logic [3:0]  cnt_d3,
    output logic [3:0]  cnt_d4,
    output logic [3:0]  cnt_d5,
    output logic [3:0]  cnt_d6,
    output logic [3:0]  cnt_d7,
    output logic        dp0,
    output logic        dp1,
    output logic        dp2,
    output logic        dp3,
    output logic        dp4,
    output logic        dp5,
    output logic        dp6,
    output logic        dp7,
    output logic [2:0]  seven_seg_scan,
    output logic        sec_tick,
    output logic        ovf,
    output logic        run
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX  = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRE_HALF = PW'(TICK_DIV / 2);
    localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);

    state_e          state_q, state_d;
    logic [PW-1:0]   pre_q, pre_d;
    logic [SW-1:0]   scan_div_q, scan_div_d;
    logic [2:0]      scan_q, scan_d;
    logic            sec_tick_q, sec_tick_d;
    logic            ovf_q, ovf_d;
    logic            tick_raw;
    logic            tick_en;
    logic [NUM_DIGITS:0] carry;
    logic [3:0]      digit [NUM_DIGITS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= STOP;
            pre_q      <= '0;
            scan_div_q <= '0;
            scan_q     <= 3'd0;
            sec_tick_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_q      <= pre_d;
            scan_div_q <= scan_div_d;
            scan_q     <= scan_d;
            sec_tick_q <= sec_tick_d;
            ovf_q      <= ovf_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pre_d      = pre_q;
        scan_div_d = scan_div_q + 1'b1;
        scan_d     = scan_q;
        tick_raw   = (state_q == RUN) && (pre_q == PRE_MAX);
        // A coincident clr/load swallows the tick; it is not replayed later.
        tick_en    = tick_raw && !clr && !load;
        sec_tick_d = tick_en;
        ovf_d      = carry[NUM_DIGITS];

        if (start_stop) begin
            state_d = (state_q == RUN) ? STOP : RUN;
        end

        if (state_q == RUN) begin
            pre_d = tick_raw ? '0 : pre_q + 1'b1;
        end
        if (clr) begin
            pre_d = '0;
        end

        if (scan_div_q == SCAN_MAX) begin
            scan_div_d = '0;
            scan_d     = scan_q + 3'd1;
        end
    end

    assign carry[0] = tick_en;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .clk      (clk),
            .rst_n    (rst_n),
            .clr      (clr),
            .load     (load),
            .load_nib (load_val[4*i +: 4]),
            .cin      (carry[i]),
            .q        (digit[i]),
            .cout     (carry[i+1])
        );
    end

    assign cnt_d0 = digit[0];
    assign cnt_d1 = digit[1];
    assign cnt_d2 = digit[2];
    assign cnt_d3 = digit[3];
    assign cnt_d4 = digit[4];
    assign cnt_d5 = digit[5];
    assign cnt_d6 = digit[6];
    assign cnt_d7 = digit[7];

    assign run            = (state_q == RUN);
    assign sec_tick       = sec_tick_q;
    assign ovf            = ovf_q;
    assign seven_seg_scan = scan_q;

    // Heartbeat: lit for the first half of every second while running.
    assign dp0 = run && (pre_q < PRE_HALF);
    assign dp1 = 1'b0;
    assign dp2 = 1'b0;
    assign dp3 = 1'b0;
    assign dp4 = 1'b0;
    assign dp5 = 1'b0;
    assign dp6 = 1'b0;
    assign dp7 = 1'b0;

endmodule

// File: tb/tb_sec_bcd_counter.sv
// Scoreboard bench for sec_bcd_counter: an integer-seconds reference model
// queues expected outputs per edge; a monitor pops and compares after each edge.
module tb_sec_bcd_counter;

    localparam int TD = 4;
    localparam int SD = 2;

    logic        clk = 1'b0;
    logic        rst_n, start_stop, clr, load;
    logic [31:0] load_val;
    logic [3:0]  cnt_d0, cnt_d1, cnt_d2, cnt_d3, cnt_d4, cnt_d5, cnt_d6, cnt_d7;
    logic        dp0, dp1, dp2, dp3, dp4, dp5, dp6, dp7;
    logic [2:0]  seven_seg_scan;
    logic        sec_tick, ovf, run;

    sec_bcd_counter #(.TICK_DIV(TD), .SCAN_DIV(SD)) dut (
        .clk(clk), .rst_n(rst_n), .start_stop(start_stop), .clr(clr),
        .load(load), .load_val(load_val),
        .cnt_d0(cnt_d0), .cnt_d1(cnt_d1), .cnt_d2(cnt_d2), .cnt_d3(cnt_d3),
        .cnt_d4(cnt_d4), .cnt_d5(cnt_d5), .cnt_d6(cnt_d6), .cnt_d7(cnt_d7),
        .dp0(dp0), .dp1(dp1), .dp2(dp2), .dp3(dp3),
        .dp4(dp4), .dp5(dp5), .dp6(dp6), .dp7(dp7),
        .seven_seg_scan(seven_seg_scan), .sec_tick(sec_tick), .ovf(ovf), .run(run)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned secs;
        bit          tick;
        bit          ovf;
        bit          run;
        bit          dp0;
        bit [2:0]    scan;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad   = 0;

    int unsigned m_secs = 0;
    int          m_pre  = 0;
    bit          m_run  = 1'b0;
    longint      m_cyc  = 0;
    bit          m_tick = 1'b0;
    bit          m_ovf  = 1'b0;

    function automatic logic [31:0] to_bcd(input int unsigned v);
        logic [31:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int unsigned from_load(input logic [31:0] lv);
        int unsigned v;
        int unsigned w;
        int unsigned n;
        v = 0;
        w = 1;
        for (int i = 0; i < 8; i++) begin
            n = 32'(lv[4*i +: 4]);
            if (n > 9) n = 0;
            v = v + n * w;
            w = w * 10;
        end
        return v;
    endfunction

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, req);
        end
    endtask

    task automatic step(input bit rn, input bit ss, input bit c, input bit l,
                        input logic [31:0] lv);
        bit   fire;
        exp_t e;
        @(negedge clk);
        rst_n      = rn;
        start_stop = ss;
        clr        = c;
        load       = l;
        load_val   = lv;
        if (!rn) begin
            m_secs = 0; m_pre = 0; m_run = 1'b0; m_cyc = 0;
            m_tick = 1'b0; m_ovf = 1'b0;
        end else begin
            fire   = m_run && (m_pre == TD - 1);
            m_tick = 1'b0;
            m_ovf  = 1'b0;
            if (m_run) m_pre = (m_pre + 1) % TD;
            if (c) begin
                m_pre  = 0;
                m_secs = 0;
            end else if (l) begin
                m_secs = from_load(lv);
            end else if (fire) begin
                m_secs = (m_secs + 1) % 100000000;
                m_tick = 1'b1;
                m_ovf  = (m_secs == 0);
            end
            if (ss) m_run = !m_run;
            m_cyc++;
        end
        e.secs = m_secs;
        e.tick = m_tick;
        e.ovf  = m_ovf;
        e.run  = m_run;
        e.dp0  = m_run && (m_pre < TD / 2);
        e.scan = 3'((m_cyc / SD) % 8);
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic wait_pre(input int target);
        for (int i = 0; i < 2 * TD && !(m_run && m_pre == target); i++) idle(1);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                check("digits", {cnt_d7, cnt_d6, cnt_d5, cnt_d4, cnt_d3, cnt_d2, cnt_d1, cnt_d0},
                      to_bcd(mon_e.secs));
                check("sec_tick", sec_tick, mon_e.tick);
                check("ovf", ovf, mon_e.ovf);
                check("run", run, mon_e.run);
                check("dp0", dp0, mon_e.dp0);
                check("scan", seven_seg_scan, mon_e.scan);
                check("dp_hi", {dp7, dp6, dp5, dp4, dp3, dp2, dp1}, 0);
            end
        end
    end

    initial begin
        logic [31:0] lv;
        rst_n = 1'b0; start_stop = 1'b0; clr = 1'b0; load = 1'b0; load_val = '0;

        repeat (3) step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), $urandom);

        idle(2);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        idle(45);

        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h99999999);
        idle(6);
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000A3F5);
        idle(2);

        wait_pre(1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        idle(10);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        idle(6);

        wait_pre(TD - 1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        idle(3);
        wait_pre(TD - 1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h12345678);
        idle(2);
        step(1'b1, 1'b0, 1'b1, 1'b1, 32'h00000055);
        idle(2);
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        idle(5);
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        idle(6);

        step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 32'h0);
        idle(5);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        idle(10);

        repeat (600) begin
            case ($urandom_range(0, 2))
                0:       lv = $urandom;
                1:       lv = 32'h99999990 | 32'($urandom_range(0, 9));
                default: lv = to_bcd($urandom_range(0, 99999999));
            endcase
            step(1'($urandom_range(0, 99) != 0), 1'($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 31) == 0), lv);
        end

        idle(1);
        repeat (3) @(posedge clk);
        #2;
        check("drain", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
